// File: rtl/uart_pkg.sv
// Shared UART definitions: TX/RX state encoding and parity selection constants.
// Imported by both the transmitter and the receiver.
package uart_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_transmitter_serializer.sv
// Shift register and bit index for the UART transmitter.
// The data word goes out LSB first; last_bit flags the final data bit.
module uart_transmitter_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_load,
    input  logic                  i_shift,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_bit,
    output logic                  o_last_bit
);

    localparam int IDX_W = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] r_shift;
    logic [IDX_W-1:0]      r_index;

    // The index saturates on the last bit so it never wraps back to zero.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_shift <= '0;
            r_index <= '0;
        end else if (i_load) begin
            r_shift <= i_data;
            r_index <= '0;
        end else if (i_shift) begin
            r_shift <= {1'b0, r_shift[DATA_WIDTH-1:1]};
            if (!o_last_bit) begin
                r_index <= r_index + 1'b1;
            end
        end
    end

    assign o_bit      = r_shift[0];
    assign o_last_bit = (r_index == IDX_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// One bit per clock; the line and busy outputs are registered copies of the decoded state.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_parallel_data,
    input  logic                  i_data_valid,
    input  logic                  i_parity_enable,
    input  logic                  i_parity_type,
    output logic                  o_serial_data,
    output logic                  o_busy
);

    tx_state_t r_state;
    tx_state_t w_next_state;

    logic w_load;
    logic w_shift;
    logic w_bit;
    logic w_last_bit;
    logic w_line;
    logic w_busy;
    logic r_parity_enable;
    logic r_parity_bit;

    uart_transmitter_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_load),
        .i_shift    (w_shift),
        .i_data     (i_parallel_data),
        .o_bit      (w_bit),
        .o_last_bit (w_last_bit)
    );

    // Parity is resolved at acceptance since the shift register consumes the word.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= ST_IDLE;
            o_serial_data   <= 1'b1;
            o_busy          <= 1'b0;
            r_parity_enable <= 1'b0;
            r_parity_bit    <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            o_serial_data <= w_line;
            o_busy        <= w_busy;
            if (w_load) begin
                r_parity_enable <= i_parity_enable;
                r_parity_bit    <= (^i_parallel_data) ^ (i_parity_type == PARITY_ODD);
            end
        end
    end

    always_comb begin
        w_next_state = ST_IDLE;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_line       = 1'b1;
        w_busy       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_data_valid) begin
                    w_next_state = ST_START;
                    w_load       = 1'b1;
                end
            end
            ST_START: begin
                w_line       = 1'b0;
                w_busy       = 1'b1;
                w_next_state = ST_DATA;
            end
            ST_DATA: begin
                w_line       = w_bit;
                w_busy       = 1'b1;
                w_shift      = 1'b1;
                w_next_state = ST_DATA;
                if (w_last_bit) begin
                    w_next_state = r_parity_enable ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                w_line       = r_parity_bit;
                w_busy       = 1'b1;
                w_next_state = ST_STOP;
            end
            ST_STOP: begin
                w_line = 1'b1;
                w_busy = 1'b1;
                if (i_data_valid) begin
                    w_next_state = ST_START;
                    w_load       = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: directed frames plus randomized words
// compared against a bit-list model of the UART frame format.
module tb_uart_transmitter;

    logic       clk;
    logic       reset;
    logic [7:0] parallelData;
    logic       dataValid;
    logic       parityEnable;
    logic       parityType;
    logic       serialData;
    logic       busy;

    int total = 0;
    int bad   = 0;
    bit expBits[$];

    uart_transmitter #(
        .DATA_WIDTH (8)
    ) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_parallel_data (parallelData),
        .i_data_valid    (dataValid),
        .i_parity_enable (parityEnable),
        .i_parity_type   (parityType),
        .o_serial_data   (serialData),
        .o_busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] w, input logic pe, input logic pt, input logic v);
        parallelData = w;
        parityEnable = pe;
        parityType   = pt;
        dataValid    = v;
    endtask

    // Reference frame: start 0, data LSB first, optional parity, stop 1.
    task automatic pushFrame(input logic [7:0] w, input logic pe, input logic pt);
        expBits.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            expBits.push_back(bit'((w >> i) & 8'd1));
        end
        if (pe) begin
            expBits.push_back(bit'(($countones(w) + int'(pt)) % 2));
        end
        expBits.push_back(1'b1);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_line"}, serialData, 1'b1);
        checkOutput({tag, "_busy"}, busy, 1'b0);
    endtask

    // Starts at a negedge with the DUT idle; optionally scrambles inputs mid-frame
    // and pulses data_valid while the data bits are on the line.
    task automatic runFrame(input logic [7:0] w, input logic pe, input logic pt, input bit scramble);
        expBits.delete();
        pushFrame(w, pe, pt);
        applyStimulus(w, pe, pt, 1'b1);
        @(negedge clk);
        dataValid = 1'b0;
        checkIdle("latency");
        for (int j = 0; j < expBits.size(); j++) begin
            @(negedge clk);
            checkOutput($sformatf("bit%0d_w%02h", j, w), serialData, expBits[j]);
            checkOutput($sformatf("busy%0d_w%02h", j, w), busy, 1'b1);
            if (scramble) begin
                applyStimulus(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)), (j == 4));
            end
        end
        dataValid = 1'b0;
        @(negedge clk);
        checkIdle($sformatf("after_w%02h", w));
    endtask

    initial begin
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkIdle("reset");
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkIdle($sformatf("idle%0d", i));
        end

        runFrame(8'hA5, 1'b0, 1'b0, 1'b0);
        runFrame(8'hA5, 1'b1, 1'b0, 1'b0);
        runFrame(8'hA5, 1'b1, 1'b1, 1'b0);
        runFrame(8'h07, 1'b1, 1'b1, 1'b0);

        for (int n = 0; n < 8; n++) begin
            runFrame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'b1);
        end

        // Back-to-back: valid held through the first stop bit.
        expBits.delete();
        pushFrame(8'h3C, 1'b0, 1'b0);
        pushFrame(8'hC3, 1'b0, 1'b0);
        applyStimulus(8'h3C, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        parallelData = 8'hC3;
        checkIdle("b2b_latency");
        for (int j = 0; j < expBits.size(); j++) begin
            @(negedge clk);
            checkOutput($sformatf("b2b_bit%0d", j), serialData, expBits[j]);
            checkOutput($sformatf("b2b_busy%0d", j), busy, 1'b1);
            if (j == 10) begin
                dataValid = 1'b0;
            end
        end
        @(negedge clk);
        checkIdle("b2b_after");

        // Reset while data bit 3 is on the line aborts the frame.
        expBits.delete();
        pushFrame(8'h5A, 1'b1, 1'b0);
        applyStimulus(8'h5A, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        dataValid = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            checkOutput($sformatf("abort_bit%0d", j), serialData, expBits[j]);
        end
        reset = 1'b1;
        @(negedge clk);
        checkIdle("abort_reset");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkIdle($sformatf("abort_idle%0d", i));
        end
        runFrame(8'($urandom_range(0, 255)), 1'b1, 1'($urandom_range(0, 1)), 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
